// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and constants for the instruction-cache refill controller.
//   refill_state_e   : controller state encoding
//   BURST_INCR       : AXI INCR burst type
//   RESP_SLVERR/DECERR : AXI read responses that mark a failed beat
//   beats_per_block / block_offset / beat_size : geometry helpers
package icache_refill_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        AR_REQ = 2'd1,
        R_DATA = 2'd2,
        FILL   = 2'd3
    } refill_state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int beats_per_block(input int block_width, input int data_width);
        return block_width / data_width;
    endfunction

    function automatic int block_offset(input int block_width);
        return $clog2(block_width / 8);
    endfunction

    function automatic int beat_size(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// AXI4 read-channel bundle between the refill controller and memory.
//   AR: ar_valid, ar_ready, ar_addr, ar_len, ar_size, ar_burst
//   R : r_valid, r_ready, r_data, r_last, r_resp
//   master modport: controller side (issues AR, accepts R)
//   slave modport : memory/interconnect side
interface icache_refill_ctrl_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic [1:0]            r_resp;

    modport master (
        output ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        input  ar_ready, r_valid, r_data, r_last, r_resp
    );

    modport slave (
        input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        output ar_ready, r_valid, r_data, r_last, r_resp
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss controller. On a fetch miss it stalls fetch, issues
// one AXI4 INCR burst for the aligned block, assembles the beats into a block
// buffer and writes the block into the icache with a one-cycle pulse.
//   i_clk, i_arst_n : clock, asynchronous active-low reset
//   i_fetch_req, i_pc, i_icache_hit : fetch-stage lookup
//   o_stall_fetch   : hold the PC register
//   o_instr_we, o_instr_block : icache block write
//   o_bus_error     : one-cycle pulse on an errored or malformed refill
//   axi             : AXI read master port
//
// state  | meaning
// IDLE   | no refill; stall follows the current lookup miss
// AR_REQ | read address presented, waiting for ar_ready
// R_DATA | collecting beats into the block buffer
// FILL   | one cycle: write block, or flag the bus error
module icache_refill_ctrl
    import icache_refill_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WIDTH = 512,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                   i_clk,
    input  logic                   i_arst_n,
    input  logic                   i_fetch_req,
    input  logic [ADDR_WIDTH-1:0]  i_pc,
    input  logic                   i_icache_hit,
    output logic                   o_stall_fetch,
    output logic                   o_instr_we,
    output logic [BLOCK_WIDTH-1:0] o_instr_block,
    output logic                   o_bus_error,
    icache_refill_ctrl_if.master   axi
);

    localparam int BEATS  = beats_per_block(BLOCK_WIDTH, DATA_WIDTH);
    localparam int OFFSET = block_offset(BLOCK_WIDTH);
    localparam int SIZE   = beat_size(DATA_WIDTH);
    localparam int CNT_W  = $clog2(BEATS);

    refill_state_e          state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   err_q;
    logic [BLOCK_WIDTH-1:0] buffer_q;
    logic                   ar_valid_q;
    logic                   r_ready_q;
    logic                   instr_we_q;
    logic                   bus_error_q;

    logic miss;
    logic cnt_is_last;
    logic beat_err;
    logic err_next;
    logic burst_end;
    logic unused_pc;

    assign miss        = i_fetch_req & ~i_icache_hit;
    assign cnt_is_last = (cnt_q == CNT_W'(BEATS - 1));

    // A beat is bad on an error response, or when r_last disagrees with the
    // beat position (early last, or a missing last on the final beat).
    assign beat_err  = (axi.r_resp == RESP_SLVERR) | (axi.r_resp == RESP_DECERR)
                     | (axi.r_last != cnt_is_last);
    assign err_next  = err_q | beat_err;
    assign burst_end = axi.r_last | cnt_is_last;

    // The low PC bits only select within the block; the refill is block-aligned.
    assign unused_pc = ^i_pc[OFFSET-1:0];

    // Miss-cycle stall is combinational so the PC holds in the miss cycle
    // itself; gated by reset so every output reads 0 while reset is held.
    assign o_stall_fetch = i_arst_n & ((state_q != IDLE) | miss);

    assign o_instr_we    = instr_we_q;
    assign o_bus_error   = bus_error_q;
    assign o_instr_block = buffer_q;

    assign axi.ar_valid  = ar_valid_q;
    assign axi.ar_addr   = addr_q;
    assign axi.ar_len    = 8'(BEATS - 1);
    assign axi.ar_size   = 3'(SIZE);
    assign axi.ar_burst  = BURST_INCR;
    assign axi.r_ready   = r_ready_q;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            buffer_q    <= '0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            instr_we_q  <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            instr_we_q  <= 1'b0;
            bus_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        addr_q     <= {i_pc[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
                        ar_valid_q <= 1'b1;
                        state_q    <= AR_REQ;
                    end
                end
                AR_REQ: begin
                    if (axi.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        cnt_q      <= '0;
                        err_q      <= 1'b0;
                        state_q    <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi.r_valid) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (cnt_q == CNT_W'(b)) begin
                                buffer_q[b*DATA_WIDTH +: DATA_WIDTH] <= axi.r_data;
                            end
                        end
                        cnt_q <= cnt_q + 1'b1;
                        err_q <= err_next;
                        if (burst_end) begin
                            r_ready_q   <= 1'b0;
                            instr_we_q  <= ~err_next;
                            bus_error_q <= err_next;
                            state_q     <= FILL;
                        end
                    end
                end
                FILL: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: a table of directed refills,
// a hand-written reset-mid-burst sequence, and randomized refills checked
// against a transaction-level latency/outcome model.
module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fetch_req = 1'b0;
    logic [63:0]  pc = '0;
    logic         hit = 1'b0;
    logic         stall;
    logic         we;
    logic         berr;
    logic [511:0] block;

    int n_checks = 0;
    int n_errors = 0;

    icache_refill_ctrl_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) axi ();

    icache_refill_ctrl #(
        .ADDR_WIDTH (64),
        .BLOCK_WIDTH(512),
        .DATA_WIDTH (64)
    ) dut (
        .i_clk        (clk),
        .i_arst_n     (rst_n),
        .i_fetch_req  (fetch_req),
        .i_pc         (pc),
        .i_icache_hit (hit),
        .o_stall_fetch(stall),
        .o_instr_we   (we),
        .o_instr_block(block),
        .o_bus_error  (berr),
        .axi          (axi.master)
    );

    always #5 clk = ~clk;

    // memory contents returned for the current block, beat 0 first
    logic [63:0]  beat_data [8];
    logic [1:0]   ok_resp = 2'b00;

    // observations from one refill run
    int           res_stall, res_we, res_err, res_hs, res_addr_changes, res_retry_gap;
    bit           res_timeout;
    logic [63:0]  res_addr_first;
    logic [12:0]  res_arcfg;
    logic [511:0] res_block;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycles from the miss cycle to the re-lookup, for n beats separated by g idle cycles
    function automatic int ref_latency(input int w, input int n, input int g);
        return 3 + w + n + g * (n - 1);
    endfunction

    // Acts as the fetch stage plus an AXI slave for one miss (and any retry),
    // until the stall drops. rst_beat >= 0 asserts reset when that beat is due.
    task automatic run_refill(input logic [63:0] run_pc, input int w, input int gap,
                              input int err_beat_in, input logic [1:0] err_resp,
                              input int last_in, input int rst_beat);
        int err_beat, last_idx, cyc, ar_cnt, bi, gap_left, err_cyc;
        bit r_phase, hit_flag, done, first_ar, start_r;
        err_beat = err_beat_in; last_idx = last_in;
        cyc = 0; ar_cnt = 0; bi = 0; gap_left = 0; err_cyc = -1;
        r_phase = 0; hit_flag = 0; done = 0; first_ar = 1;
        res_stall = 0; res_we = 0; res_err = 0; res_hs = 0; res_addr_changes = 0;
        res_retry_gap = -1; res_timeout = 0; res_addr_first = '0; res_arcfg = '0; res_block = '0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (we) begin res_we++; res_block = block; hit_flag = 1; end
            if (berr) begin res_err++; err_cyc = cyc; end
            if (axi.ar_valid) begin
                if (first_ar) begin
                    res_addr_first = axi.ar_addr;
                    res_arcfg = {axi.ar_len, axi.ar_size, axi.ar_burst};
                    first_ar = 0;
                end else if (axi.ar_addr !== res_addr_first) begin
                    res_addr_changes++;
                end
                if (err_cyc >= 0 && res_retry_gap < 0) res_retry_gap = cyc - err_cyc;
            end
            start_r = 0;
            axi.ar_ready = 1'b0;
            if (axi.ar_valid) begin
                if (ar_cnt == w) begin
                    axi.ar_ready = 1'b1; ar_cnt = 0; res_hs++; start_r = 1;
                end else begin
                    ar_cnt++;
                end
            end
            axi.r_valid = 1'b0; axi.r_last = 1'b0; axi.r_resp = 2'b00; axi.r_data = '0;
            if (r_phase && axi.r_ready) begin
                if (gap_left > 0) begin
                    gap_left--;
                end else if (bi == rst_beat) begin
                    axi.ar_ready = 1'b0;
                    rst_n = 1'b0;
                    #1;
                    chk("reset_mid_burst outputs", {stall, we, berr, axi.ar_valid, axi.r_ready}, 5'b0);
                    chk("reset_mid_burst block", block, 512'b0);
                    return;
                end else begin
                    axi.r_valid = 1'b1;
                    axi.r_data  = beat_data[bi];
                    axi.r_resp  = (bi == err_beat) ? err_resp : ok_resp;
                    axi.r_last  = (bi == last_idx);
                    bi++;
                    gap_left = gap;
                    if (bi - 1 == last_idx || bi == 8) begin
                        r_phase = 0; err_beat = -1; last_idx = 7;
                    end
                end
            end
            if (start_r) begin r_phase = 1; bi = 0; gap_left = 0; end
            fetch_req = 1'b1; pc = run_pc; hit = hit_flag;
            #1;
            if (stall) res_stall++; else done = 1;
            if (cyc >= 500) begin res_timeout = 1; done = 1; end
        end
    endtask

    task automatic check_run(input string tag, input int exp_stall, input int exp_err,
                             input int exp_hs, input int exp_gap, input logic [63:0] exp_addr);
        logic [511:0] exp_block;
        for (int i = 0; i < 8; i++) exp_block[i*64 +: 64] = beat_data[i];
        chk({tag, " timeout"}, 512'(res_timeout), 512'd0);
        chk({tag, " stall_cycles"}, res_stall, exp_stall);
        chk({tag, " we_pulses"}, res_we, 1);
        chk({tag, " bus_error_pulses"}, res_err, exp_err);
        chk({tag, " ar_handshakes"}, res_hs, exp_hs);
        chk({tag, " retry_gap"}, res_retry_gap, exp_gap);
        chk({tag, " ar_addr"}, res_addr_first, exp_addr);
        chk({tag, " ar_addr_changes"}, res_addr_changes, 0);
        chk({tag, " ar_len_size_burst"}, res_arcfg, {8'd7, 3'd3, 2'b01});
        chk({tag, " block"}, res_block, exp_block);
    endtask

    typedef struct {
        logic [63:0] pc;
        int          w;
        int          gap;
        int          err_beat;
        logic [1:0]  err_resp;
        int          last_idx;
        int          exp_stall;
        int          exp_err;
        int          exp_hs;
        int          exp_gap;
        logic [63:0] exp_addr;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int sc, ac, wc;
        axi.ar_ready = 1'b0; axi.r_valid = 1'b0; axi.r_last = 1'b0;
        axi.r_resp = 2'b00; axi.r_data = '0;

        vecs[0] = '{64'h0000_0000_8000_0044, 0, 0, -1, 2'b00, 7, 11, 0, 1, -1, 64'h0000_0000_8000_0040};
        vecs[1] = '{64'h0000_0000_8000_0044, 5, 2, -1, 2'b00, 7, 30, 0, 1, -1, 64'h0000_0000_8000_0040};
        vecs[2] = '{64'h0000_0000_8000_0044, 0, 0,  4, 2'b10, 7, 22, 1, 2,  2, 64'h0000_0000_8000_0040};
        vecs[3] = '{64'h0000_0000_8000_0044, 0, 0, -1, 2'b00, 3, 18, 1, 2,  2, 64'h0000_0000_8000_0040};

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset outputs", {stall, we, berr, axi.ar_valid, axi.r_ready}, 5'b0);
        chk("reset block", block, 512'b0);
        chk("reset ar_len_size_burst", {axi.ar_len, axi.ar_size, axi.ar_burst}, {8'd7, 3'd3, 2'b01});
        @(negedge clk);
        rst_n = 1'b1;

        // continuous hits: no stall, no AR
        sc = 0; ac = 0; wc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (axi.ar_valid) ac++;
            if (we || berr) wc++;
            fetch_req = 1'b1; hit = 1'b1; pc = {$urandom, $urandom};
            #1;
            if (stall) sc++;
        end
        chk("hit_run stall_cycles", sc, 0);
        chk("hit_run ar_valid_cycles", ac, 0);
        chk("hit_run write_or_error", wc, 0);

        // directed table
        for (int i = 0; i < 8; i++) beat_data[i] = 64'h11 * (i + 1);
        for (int v = 0; v < 4; v++) begin
            run_refill(vecs[v].pc, vecs[v].w, vecs[v].gap, vecs[v].err_beat,
                       vecs[v].err_resp, vecs[v].last_idx, -1);
            check_run($sformatf("vec%0d", v), vecs[v].exp_stall, vecs[v].exp_err,
                      vecs[v].exp_hs, vecs[v].exp_gap, vecs[v].exp_addr);
        end
        chk("vec0 block_low_beat", res_block[63:0], 64'h11);
        chk("vec0 block_high_beat", res_block[511:448], 64'h88);

        // reset during beat 5, then a clean refill must restart from beat 0
        run_refill(64'h0000_0000_8000_0044, 0, 0, -1, 2'b00, 7, 5);
        fetch_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) beat_data[i] = {$urandom, $urandom};
        run_refill(64'h0000_1234_5678_9ABC, 0, 0, -1, 2'b00, 7, -1);
        check_run("after_reset", 11, 0, 1, -1, 64'h0000_1234_5678_9A80);

        // randomized refills against the transaction model
        for (int t = 0; t < 30; t++) begin
            logic [63:0] rpc;
            int w, g, eb, last, n, r, exp_stall;
            bit err;
            logic [1:0] eresp;
            rpc = {$urandom, $urandom};
            w = $urandom_range(0, 3);
            g = $urandom_range(0, 2);
            eb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1;
            eresp = $urandom_range(0, 1) ? 2'b10 : 2'b11;
            r = $urandom_range(0, 5);
            last = (r == 0) ? $urandom_range(0, 6) : (r == 1) ? 8 : 7;
            ok_resp = $urandom_range(0, 1) ? 2'b01 : 2'b00;
            for (int i = 0; i < 8; i++) beat_data[i] = {$urandom, $urandom};
            n = (last < 7) ? last + 1 : 8;
            err = (last != 7) || (eb >= 0 && eb < n);
            exp_stall = ref_latency(w, n, g) + (err ? ref_latency(w, 8, g) : 0);
            run_refill(rpc, w, g, eb, eresp, last, -1);
            check_run($sformatf("rand%0d", t), exp_stall, err ? 1 : 0, err ? 2 : 1,
                      err ? 2 : -1, rpc & ~64'h3f);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
